alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rstn, input, 1 bit: reset is synchronous and active-high (asserted when rstn=1, sampled only on the rising edge of clk).
REQ-003 The block SHALL have the port OPCODE, input, 3 bits: operation select.
REQ-004 The block SHALL have the port OP1, input, 4 bits: first operand, unsigned or two's complement per operation.
REQ-005 The block SHALL have the port OP2, input, 4 bits: second operand, or shift amount for shift operations.
REQ-006 The block SHALL have the port RESULT, output, 4 bits: registered operation result.
REQ-007 The block SHALL have the port CARRY, output, 1 bit: registered carry, borrow or shifted-out bit.
REQ-008 The block SHALL have the port OVF, output, 1 bit: registered signed overflow.
REQ-009 The block SHALL have the port ZERO, output, 1 bit: registered flag, RESULT==0.
REQ-010 The block SHALL have the port NEG, output, 1 bit: registered flag, RESULT[3].
REQ-011 The block SHALL have the port VALID, output, 1 bit: registered flag, outputs hold a computed result.
REQ-012 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-013 The block SHALL sample OPCODE/OP1/OP2 on every rising clk edge with rstn=0 and present the result on the outputs after that edge (latency 1 cycle, no handshake, one operation per cycle).
REQ-014 OPCODE 000 ADD SHALL produce {CARRY,RESULT}=OP1+OP2 (5-bit sum); OVF=1 when OP1[3]==OP2[3] and RESULT[3]!=OP1[3].
REQ-015 OPCODE 001 SUB SHALL produce RESULT=(OP1-OP2) mod 16; CARRY=1 when OP1<OP2 unsigned (borrow); OVF=1 when OP1[3]!=OP2[3] and RESULT[3]!=OP1[3].
REQ-016 OPCODE 010 AND SHALL produce RESULT=OP1&OP2.
REQ-017 OPCODE 011 OR SHALL produce RESULT=OP1|OP2.
REQ-018 OPCODE 100 XOR SHALL produce RESULT=OP1^OP2.
REQ-019 OPCODE 101 NOT SHALL produce RESULT=~OP1; OP2 is ignored.
REQ-020 OPCODE 110 SHL SHALL produce RESULT=OP1<<OP2[1:0], zero-filled; CARRY = last bit shifted out (OP1[4-n] for n=OP2[1:0]>0, else 0); OP2[3:2] ignored.
REQ-021 OPCODE 111 SHR (logical) SHALL produce RESULT=OP1>>OP2[1:0], zero-filled; CARRY = last bit shifted out (OP1[n-1] for n>0, else 0).
REQ-022 For opcodes 010-101 the block SHALL drive CARRY=0 and OVF=0; for shifts it SHALL drive OVF=0.
REQ-023 For all opcodes the block SHALL drive ZERO=(RESULT==4'b0000) and NEG=RESULT[3], computed from the same cycle's result.
REQ-024 The block SHALL drive VALID=1 on every edge with rstn=0.
REQ-025 The block SHALL have no hidden state beyond the output registers; the result SHALL depend only on inputs sampled at the previous edge.

Reset
REQ-026 On any rising edge with rstn=1 the block SHALL set RESULT=0, CARRY=0, OVF=0, ZERO=0, NEG=0, VALID=0, regardless of inputs.
REQ-027 A reset asserted mid-stream SHALL discard the operation sampled at that edge; the first edge with rstn=0 SHALL produce a valid result for the inputs sampled at that edge.
REQ-028 Output values before the first clock edge are undefined; verification SHALL begin checking only after the first reset edge.

Verification
REQ-029 The bench SHALL cover: rstn=1, OPCODE=011, OP1=0001, OP2=1000, then rstn=0 with the same inputs -> after the reset edge all outputs are 0; after the next edge RESULT=1001, NEG=1, ZERO=0, CARRY=0, OVF=0, VALID=1.
REQ-030 The bench SHALL cover: ADD OP1=0111, OP2=0001 -> RESULT=1000, OVF=1, CARRY=0, NEG=1; then ADD OP1=1111, OP2=0001 -> RESULT=0000, CARRY=1, ZERO=1, OVF=0.
REQ-031 The bench SHALL cover: SUB OP1=0010, OP2=0011 -> RESULT=1111, CARRY=1, NEG=1, OVF=0; then SUB OP1=1000, OP2=0001 -> RESULT=0111, OVF=1, CARRY=0.
REQ-032 The bench SHALL cover: SHL OP1=1011, OP2=0001 -> RESULT=0110, CARRY=1; SHR OP1=1011, OP2=0010 -> RESULT=0010, CARRY=1; SHL with OP2=0100 (n=0) -> RESULT=OP1, CARRY=0.
REQ-033 The bench SHALL cover: XOR OP1=OP2=1010 -> RESULT=0000, ZERO=1; NOT OP1=1111 -> RESULT=0000, ZERO=1, CARRY=0.
REQ-034 The bench SHALL cover back-to-back operations with rstn=1 asserted for one edge mid-stream -> that edge yields all-zero outputs with VALID=0, and the following edge resumes correct results.

Source files
------------

// File: rtl/alu.sv
// 4-bit registered ALU: one operation per cycle with a latency of one clock.
// It provides add/sub, bitwise logic and 0..3-bit logical shifts, plus carry, overflow, zero and negative flags.
module alu (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] OPCODE,
  input  logic [3:0] OP1,
  input  logic [3:0] OP2,
  output logic [3:0] RESULT,
  output logic       CARRY,
  output logic       OVF,
  output logic       ZERO,
  output logic       NEG,
  output logic       VALID
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  op_e        op;
  logic [1:0] shamt;
  logic [4:0] sum;
  logic [4:0] diff;
  logic [7:0] shl_wide;
  logic [7:0] shr_wide;
  logic [3:0] result_d;
  logic       carry_d;
  logic       ovf_d;

  assign op    = op_e'(OPCODE);
  assign shamt = OP2[1:0];

  // In the 5-bit difference, bit 4 becomes the borrow whenever OP1 < OP2.
  assign sum  = {1'b0, OP1} + {1'b0, OP2};
  assign diff = {1'b0, OP1} - {1'b0, OP2};

  // The operand is widened so that the last bit shifted out lands at a fixed position (bit 4 or bit 3).
  assign shl_wide = {4'b0000, OP1} << shamt;
  assign shr_wide = {OP1, 4'b0000} >> shamt;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a value held and infer a latch.
    result_d = 4'b0000;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    case (op)
      OP_ADD: begin
        result_d = sum[3:0];
        carry_d  = sum[4];
        ovf_d    = (OP1[3] == OP2[3]) && (sum[3] != OP1[3]);
      end
      OP_SUB: begin
        result_d = diff[3:0];
        carry_d  = diff[4];
        ovf_d    = (OP1[3] != OP2[3]) && (diff[3] != OP1[3]);
      end
      OP_AND: result_d = OP1 & OP2;
      OP_OR:  result_d = OP1 | OP2;
      OP_XOR: result_d = OP1 ^ OP2;
      OP_NOT: result_d = ~OP1;
      OP_SHL: begin
        result_d = shl_wide[3:0];
        carry_d  = shl_wide[4];
      end
      OP_SHR: begin
        result_d = shr_wide[7:4];
        carry_d  = shr_wide[3];
      end
      default: result_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every register samples values from before the edge.
    if (rstn) begin
      RESULT <= 4'b0000;
      CARRY  <= 1'b0;
      OVF    <= 1'b0;
      ZERO   <= 1'b0;
      NEG    <= 1'b0;
      VALID  <= 1'b0;
    end else begin
      RESULT <= result_d;
      CARRY  <= carry_d;
      OVF    <= ovf_d;
      ZERO   <= (result_d == 4'b0000);
      NEG    <= result_d[3];
      VALID  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases plus randomized traffic.
// The random traffic is checked against an integer-arithmetic reference model.
module tb_alu;

  logic       clk;
  logic       rstn;
  logic [2:0] OPCODE;
  logic [3:0] OP1;
  logic [3:0] OP2;
  logic [3:0] RESULT;
  logic       CARRY;
  logic       OVF;
  logic       ZERO;
  logic       NEG;
  logic       VALID;

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk   (clk),
    .rstn  (rstn),
    .OPCODE(OPCODE),
    .OP1   (OP1),
    .OP2   (OP2),
    .RESULT(RESULT),
    .CARRY (CARRY),
    .OVF   (OVF),
    .ZERO  (ZERO),
    .NEG   (NEG),
    .VALID (VALID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The packed layout is {RESULT, CARRY, OVF, ZERO, NEG, VALID}.
  function automatic logic [8:0] observed();
    return {RESULT, CARRY, OVF, ZERO, NEG, VALID};
  endfunction

  // This reference model works from plain integer arithmetic on unsigned and signed operand values.
  function automatic logic [8:0] model(input logic rst, input logic [2:0] opc,
                                       input logic [3:0] a, input logic [3:0] b);
    int ua = int'(a);
    int ub = int'(b);
    int sa = (ua > 7) ? ua - 16 : ua;
    int sb = (ub > 7) ? ub - 16 : ub;
    int n  = ub % 4;
    int r  = 0;
    int c  = 0;
    int o  = 0;
    if (rst) return 9'b0;
    case (opc)
      3'd0: begin r = (ua + ub) % 16; c = int'(ua + ub > 15); o = int'(sa + sb > 7 || sa + sb < -8); end
      3'd1: begin r = (ua - ub + 16) % 16; c = int'(ua < ub); o = int'(sa - sb > 7 || sa - sb < -8); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = 15 - ua;
      3'd6: begin r = (ua * (1 << n)) % 16; c = ((ua * (1 << n)) / 16) % 2; end
      default: begin r = ua / (1 << n); c = (n == 0) ? 0 : (ua / (1 << (n - 1))) % 2; end
    endcase
    return {r[3:0], c[0], o[0], (r == 0), (r >= 8), 1'b1};
  endfunction

  task automatic apply(input logic rst, input logic [2:0] opc, input logic [3:0] a, input logic [3:0] b);
    rstn   = rst;
    OPCODE = opc;
    OP1    = a;
    OP2    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    apply(1'b1, 3'b011, 4'b0001, 4'b1000);
    got = observed();
    checks++;
    if (got !== 9'b0000_0_0_0_0_0) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", got, 9'b0);
    end
    apply(1'b0, 3'b011, 4'b0001, 4'b1000);
    got = observed();
    checks++;
    if (got !== 9'b1001_0_0_0_1_1) begin
      errors++; $display("FAIL first_after_reset: got %b expected %b", got, 9'b1001_0_0_0_1_1);
    end
  endtask

  task automatic test_add();
    logic [8:0] got;
    apply(1'b0, 3'b000, 4'b0111, 4'b0001);
    got = observed();
    checks++;
    if (got !== 9'b1000_0_1_0_1_1) begin
      errors++; $display("FAIL add_overflow: got %b expected %b", got, 9'b1000_0_1_0_1_1);
    end
    apply(1'b0, 3'b000, 4'b1111, 4'b0001);
    got = observed();
    checks++;
    if (got !== 9'b0000_1_0_1_0_1) begin
      errors++; $display("FAIL add_carry_zero: got %b expected %b", got, 9'b0000_1_0_1_0_1);
    end
  endtask

  task automatic test_sub();
    logic [8:0] got;
    apply(1'b0, 3'b001, 4'b0010, 4'b0011);
    got = observed();
    checks++;
    if (got !== 9'b1111_1_0_0_1_1) begin
      errors++; $display("FAIL sub_borrow: got %b expected %b", got, 9'b1111_1_0_0_1_1);
    end
    apply(1'b0, 3'b001, 4'b1000, 4'b0001);
    got = observed();
    checks++;
    if (got !== 9'b0111_0_1_0_0_1) begin
      errors++; $display("FAIL sub_overflow: got %b expected %b", got, 9'b0111_0_1_0_0_1);
    end
  endtask

  task automatic test_shift();
    logic [8:0] got;
    apply(1'b0, 3'b110, 4'b1011, 4'b0001);
    got = observed();
    checks++;
    if (got !== 9'b0110_1_0_0_0_1) begin
      errors++; $display("FAIL shl_by_1: got %b expected %b", got, 9'b0110_1_0_0_0_1);
    end
    apply(1'b0, 3'b111, 4'b1011, 4'b0010);
    got = observed();
    checks++;
    if (got !== 9'b0010_1_0_0_0_1) begin
      errors++; $display("FAIL shr_by_2: got %b expected %b", got, 9'b0010_1_0_0_0_1);
    end
    apply(1'b0, 3'b110, 4'b1011, 4'b0100);
    got = observed();
    checks++;
    if (got !== 9'b1011_0_0_0_1_1) begin
      errors++; $display("FAIL shl_by_0: got %b expected %b", got, 9'b1011_0_0_0_1_1);
    end
    apply(1'b0, 3'b110, 4'b0001, 4'b0011);
    got = observed();
    checks++;
    if (got !== 9'b1000_0_0_0_1_1) begin
      errors++; $display("FAIL shl_by_3: got %b expected %b", got, 9'b1000_0_0_0_1_1);
    end
  endtask

  task automatic test_logic();
    logic [8:0] got;
    apply(1'b0, 3'b100, 4'b1010, 4'b1010);
    got = observed();
    checks++;
    if (got !== 9'b0000_0_0_1_0_1) begin
      errors++; $display("FAIL xor_zero: got %b expected %b", got, 9'b0000_0_0_1_0_1);
    end
    apply(1'b0, 3'b101, 4'b1111, 4'b0110);
    got = observed();
    checks++;
    if (got !== 9'b0000_0_0_1_0_1) begin
      errors++; $display("FAIL not_zero: got %b expected %b", got, 9'b0000_0_0_1_0_1);
    end
    apply(1'b0, 3'b010, 4'b1100, 4'b1010);
    got = observed();
    checks++;
    if (got !== 9'b1000_0_0_0_1_1) begin
      errors++; $display("FAIL and_basic: got %b expected %b", got, 9'b1000_0_0_0_1_1);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] got;
    apply(1'b0, 3'b000, 4'b0011, 4'b0100);
    got = observed();
    checks++;
    if (got !== 9'b0111_0_0_0_0_1) begin
      errors++; $display("FAIL b2b_add: got %b expected %b", got, 9'b0111_0_0_0_0_1);
    end
    apply(1'b1, 3'b001, 4'b0101, 4'b0010);
    got = observed();
    checks++;
    if (got !== 9'b0) begin
      errors++; $display("FAIL b2b_reset: got %b expected %b", got, 9'b0);
    end
    apply(1'b0, 3'b001, 4'b0101, 4'b0010);
    got = observed();
    checks++;
    if (got !== 9'b0011_0_0_0_0_1) begin
      errors++; $display("FAIL b2b_resume: got %b expected %b", got, 9'b0011_0_0_0_0_1);
    end
  endtask

  task automatic test_random();
    logic [8:0] got;
    logic [8:0] exp;
    logic       rst;
    logic [2:0] opc;
    logic [3:0] a;
    logic [3:0] b;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      opc = 3'($urandom_range(0, 7));
      a   = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      apply(rst, opc, a, b);
      got = observed();
      exp = model(rst, opc, a, b);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d] rst=%b op=%b a=%b b=%b: got %b expected %b", i, rst, opc, a, b, got, exp);
      end
    end
  endtask

  initial begin
    rstn   = 1'b1;
    OPCODE = 3'b000;
    OP1    = 4'b0000;
    OP2    = 4'b0000;
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_logic();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
